// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   - op encodings (mult/multu/div/divu)
//   - controller state enum
//   - default operand width
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_e;

  // Even encodings are the signed flavours.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   div_i  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i  : upper product word / partial remainder
//   sh_i   : multiplier (shifting out LSB-first) / dividend-quotient shifter
//   m_i    : multiplicand (multiply) or divisor (divide)
//   acc_o, sh_o : register values after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] sh_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] sh_o
);

  logic [WIDTH:0] sum;    // upper half + multiplicand, carry kept
  logic [WIDTH:0] shl;    // remainder with next dividend bit shifted in
  logic [WIDTH:0] diff;   // trial subtraction
  logic           ge;

  always_comb begin
    sum  = {1'b0, acc_i} + (sh_i[0] ? {1'b0, m_i} : '0);
    shl  = {acc_i, sh_i[WIDTH-1]};
    diff = shl - {1'b0, m_i};
    ge   = ~diff[WIDTH];
    acc_o = '0;
    sh_o  = '0;
    if (div_i) begin
      // Remainder stays below the divisor, so it always fits WIDTH bits.
      acc_o = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
      sh_o  = {sh_i[WIDTH-2:0], ge};
    end else begin
      // {carry, sum, multiplier} shifted right by one.
      acc_o = sum[WIDTH:1];
      sh_o  = {sum[0], sh_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MIPS mult/multu/div/divu sequencer owning HI/LO.
//   clk_i, rst_i (sync, active high)
//   start_i, op_i, a_i, b_i : operation issue, sampled only in IDLE
//   hi_we_i, lo_we_i, wdata_i : mthi/mtlo, honoured only in IDLE
//   busy_o : operation in flight (stall), done_o : one-cycle result pulse
//   hi_o, lo_o : HI/LO registers (mfhi/mflo)
// Latency: start at edge E0, HI/LO written at E33, done_o during the cycle after.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [1:0]       op_q;
  logic             sa_q, sb_q, bz_q;
  logic [WIDTH-1:0] a_raw_q, m_q, acc_q, sh_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             sgn_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_acc, step_sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (state_q == DIV),
    .acc_i (acc_q),
    .sh_i  (sh_q),
    .m_i   (m_q),
    .acc_o (step_acc),
    .sh_o  (step_sh)
  );

  // Iterations run on magnitudes; signs are re-applied in FIX.
  always_comb begin
    sgn_in = op_is_signed(op_i);
    mag_a  = (sgn_in & a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b  = (sgn_in & b_i[WIDTH-1]) ? -b_i : b_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_i) state_d = op_i[1] ? DIV : MUL;
      MUL, DIV: if (cnt_q == LAST) state_d = FIX;
      FIX:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Sign fix-up. sa_q/sb_q are already zero for unsigned ops.
  always_comb begin
    prod   = {acc_q, sh_q};
    res_hi = '0;
    res_lo = '0;
    if (op_q[1]) begin
      if (bz_q) begin
        res_lo = '1;
        res_hi = a_raw_q;
      end else begin
        res_lo = (sa_q ^ sb_q) ? -sh_q : sh_q;
        res_hi = sa_q ? -acc_q : acc_q;
      end
    end else begin
      if (sa_q ^ sb_q) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      a_raw_q <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (start_i) begin
            op_q    <= op_i;
            sa_q    <= sgn_in & a_i[WIDTH-1];
            sb_q    <= sgn_in & b_i[WIDTH-1];
            bz_q    <= (b_i == '0);
            a_raw_q <= a_i;
            cnt_q   <= '0;
            acc_q   <= '0;
            // Multiply shifts the multiplier; divide shifts the dividend.
            m_q     <= op_i[1] ? mag_b : mag_a;
            sh_q    <= op_i[1] ? mag_a : mag_b;
          end
        end
        MUL, DIV: begin
          acc_q <= step_acc;
          sh_q  <= step_sh;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0;
  logic        hi_we = 0, lo_we = 0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int passes = 0;

  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = 0, cur_lo = 0, old_hi;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Reference: plain 64-bit arithmetic with MIPS divide-by-zero rule.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, p, q, r;
    logic [63:0] pu, qu, ru;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy; pu = p; h = pu[63:32]; l = pu[31:0]; end
      2'b01: begin pu = {32'b0, x} * {32'b0, y}; h = pu[63:32]; l = pu[31:0]; end
      2'b10: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin q = sx / sy; r = sx % sy; qu = q; ru = r; l = qu[31:0]; h = ru[31:0]; end
      end
      default: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin l = x / y; h = x % y; end
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL done_unexpected: got done=1 with no op outstanding, required done=0");
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, e[63:32]});
        chk("lo", {32'b0, lo}, {32'b0, e[31:0]});
      end
    end
  end

  // Called at a negedge with the unit idle (or in its done cycle).
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit iso);
    logic [31:0] eh, el;
    int n;
    model(o, x, y, eh, el);
    old_hi = cur_hi;
    cur_hi = eh;
    cur_lo = el;
    exp_q.push_back({eh, el});
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom; op = 2'($urandom);
    chk("done_single", {63'b0, done}, 64'd0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (iso && n == 5) begin hi_we = 1; wdata = 32'h1234; start = 1; end
      @(negedge clk);
      if (iso && n == 5) begin
        hi_we = 0; start = 0;
        chk("iso_hi", {32'b0, hi}, {32'b0, old_hi});
      end
    end
    chk("busy_cycles", 64'(n), 64'd33);
    chk("done_pulse", {63'b0, done}, 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    // mtlo in the idle done cycle
    lo_we = 1; wdata = 32'hABCD;
    @(negedge clk);
    lo_we = 0;
    chk("mtlo", {32'b0, lo}, 64'h0000ABCD);
    cur_lo = 32'hABCD;

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b11, 32'd100, 32'd7, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b11, 32'd100, 32'd0, 0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0);

    // Abort mid-operation: no result and no done may follow.
    start = 1; op = 2'b00; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_hi", {32'b0, hi}, 64'd0);
    chk("abort_lo", {32'b0, lo}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    cur_hi = 0; cur_lo = 0;
    repeat (40) @(negedge clk);

    // Random back-to-back traffic.
    for (int i = 0; i < 12; i++) begin
      logic [31:0] x, y;
      int sel;
      x = $urandom;
      sel = $urandom_range(0, 3);
      y = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 20)) :
          (sel == 2) ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 3) == 0) x = 32'h8000_0000;
      do_op(2'($urandom), x, y, (i == 4));
    end

    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
